// File: rtl/ssem_pkg.sv
// Shared types for the SSEM serial accumulator ALU: operation and FSM state encodings.
package ssem_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LDN = 2'b10,
    OP_CLR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_t;

  // SUB and LDN feed the inverted B operand with carry-in 1 (two's complement).
  function automatic logic op_inverts_b(input alu_op_t op);
    return (op == OP_SUB) || (op == OP_LDN);
  endfunction

  function automatic logic op_is_arith(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ssem_serial_alu_if.sv
// Control/status handshake between the SSEM control block and the serial ALU.
interface ssem_serial_alu_if;
  import ssem_pkg::*;

  logic    load_b;
  logic    acc_to_bus;
  alu_op_t op;
  logic    start;
  logic    busy;
  logic    done;
  logic    negative;
  logic    zero;
  logic    overflow;

  modport master (
    output load_b, acc_to_bus, op, start,
    input  busy, done, negative, zero, overflow
  );

  modport slave (
    input  load_b, acc_to_bus, op, start,
    output busy, done, negative, zero, overflow
  );

endinterface

// File: rtl/ssem_serial_adder_slice.sv
// Combinational ripple adder for one chunk of the serial datapath; exposes the
// carry into the chunk MSB so the parent can form signed overflow.
module ssem_serial_adder_slice #(
  parameter int BITS = 1
) (
  input  logic [BITS-1:0] a_chunk,
  input  logic [BITS-1:0] b_chunk,
  input  logic            carry_in,
  output logic [BITS-1:0] sum_chunk,
  output logic            carry_out,
  output logic            carry_msb_in
);

  logic [BITS:0] c;

  always_comb begin
    c         = '0;
    sum_chunk = '0;
    c[0]      = carry_in;
    for (int i = 0; i < BITS; i++) begin
      sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c[i];
      c[i+1]       = (a_chunk[i] & b_chunk[i]) | (c[i] & (a_chunk[i] ^ b_chunk[i]));
    end
  end

  assign carry_out    = c[BITS];
  assign carry_msb_in = c[BITS-1];

endmodule

// File: rtl/ssem_serial_alu.sv
// Bit-serial accumulator ALU (A op B -> A), BITS_PER_CYCLE bits per clock, sharing
// the tristate system bus.
//   state | meaning
//   IDLE  | waiting; load_b/start honoured, A may drive the bus
//   RUN   | processing one chunk per clock, bus never driven
//   DONE  | one-cycle result-valid pulse, flags updated
module ssem_serial_alu
  import ssem_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] bus,
  ssem_serial_alu_if.slave ctl
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]                state;
  logic [WIDTH-1:0]          acc;
  logic [WIDTH-1:0]          b_reg;
  logic [CW-1:0]             cnt;
  logic                      carry;
  alu_op_t                   op_q;
  logic                      negative_q;
  logic                      zero_q;
  logic                      overflow_q;

  logic [BITS_PER_CYCLE-1:0] a_chunk;
  logic [BITS_PER_CYCLE-1:0] b_chunk;
  logic [BITS_PER_CYCLE-1:0] sum_chunk;
  logic                      carry_out;
  logic                      carry_msb_in;
  logic [WIDTH-1:0]          acc_next;
  logic [WIDTH-1:0]          b_next;

  always_comb begin
    a_chunk = acc[BITS_PER_CYCLE-1:0];
    b_chunk = b_reg[BITS_PER_CYCLE-1:0];
    if ((op_q == OP_LDN) || (op_q == OP_CLR)) a_chunk = '0;
    if (op_inverts_b(op_q)) b_chunk = ~b_chunk;
    if (op_q == OP_CLR) b_chunk = '0;
  end

  ssem_serial_adder_slice #(
    .BITS (BITS_PER_CYCLE)
  ) u_slice (
    .a_chunk      (a_chunk),
    .b_chunk      (b_chunk),
    .carry_in     (carry),
    .sum_chunk    (sum_chunk),
    .carry_out    (carry_out),
    .carry_msb_in (carry_msb_in)
  );

  // Shift forms stay legal even when one chunk spans the whole word.
  assign acc_next = (acc >> BITS_PER_CYCLE) | (WIDTH'(sum_chunk) << (WIDTH - BITS_PER_CYCLE));
  assign b_next   = (b_reg >> BITS_PER_CYCLE) | (b_reg << (WIDTH - BITS_PER_CYCLE));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      b_reg      <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      op_q       <= OP_ADD;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctl.load_b) b_reg <= bus;
          if (ctl.start) begin
            op_q  <= ctl.op;
            cnt   <= CNT_LAST;
            carry <= op_inverts_b(ctl.op);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          b_reg <= b_next;
          carry <= carry_out;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            state      <= S_DONE;
            negative_q <= acc_next[WIDTH-1];
            zero_q     <= (acc_next == '0);
            overflow_q <= op_is_arith(op_q) & (carry_msb_in ^ carry_out);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ctl.busy     = (state == S_RUN);
  assign ctl.done     = (state == S_DONE);
  assign ctl.negative = negative_q;
  assign ctl.zero     = zero_q;
  assign ctl.overflow = overflow_q;

  assign bus = (ctl.acc_to_bus && (state != S_RUN)) ? acc : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ssem_serial_alu.sv
// Scoreboard bench for ssem_serial_alu: one DUT with 1 bit/cycle, one with 4 bits/cycle.
module tb_ssem_serial_alu;
  import ssem_pkg::*;

  localparam int W  = 32;
  localparam int N0 = 32;
  localparam int N1 = 8;

  typedef struct {
    logic [W-1:0] a;
    logic         neg;
    logic         zr;
    logic         ov;
    int           cyc;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         load_b = 1'b0;
  logic         acc_to_bus = 1'b1;
  logic         tb_drv = 1'b0;
  logic [W-1:0] tb_val = '0;
  alu_op_t      op = OP_ADD;
  bit           sel = 1'b0;

  wire [W-1:0] bus0;
  wire [W-1:0] bus1;
  assign bus0 = tb_drv ? tb_val : {W{1'bz}};
  assign bus1 = tb_drv ? tb_val : {W{1'bz}};

  ssem_serial_alu_if if0 ();
  ssem_serial_alu_if if1 ();

  assign if0.start      = start && !sel;
  assign if0.load_b     = load_b && !sel;
  assign if0.op         = op;
  assign if0.acc_to_bus = acc_to_bus;
  assign if1.start      = start && sel;
  assign if1.load_b     = load_b && sel;
  assign if1.op         = op;
  assign if1.acc_to_bus = acc_to_bus;

  ssem_serial_alu #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .ctl(if0)
  );
  ssem_serial_alu #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .ctl(if1)
  );

  logic         busy_m, done_m, neg_m, zero_m, ov_m;
  logic [W-1:0] bus_m;
  assign busy_m = sel ? if1.busy     : if0.busy;
  assign done_m = sel ? if1.done     : if0.done;
  assign neg_m  = sel ? if1.negative : if0.negative;
  assign zero_m = sel ? if1.zero     : if0.zero;
  assign ov_m   = sel ? if1.overflow : if0.overflow;
  assign bus_m  = sel ? bus1 : bus0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  sb_t sb[$];
  sb_t e;
  logic prev_done = 1'b0;
  logic [W-1:0] m_a[2];
  logic [W-1:0] m_b[2];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // An undriven bus reads as Z in 4-state simulators and as 0 in 2-state ones.
  task automatic chk_z(input string nm, input logic [W-1:0] v);
    tests++;
    if (!((v === {W{1'bz}}) || (v === '0))) begin
      fails++;
      $display("FAIL %s: bus driven with 0x%08h expected Z", nm, v);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov);
    case (o)
      2'd0: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      2'd1: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      2'd2: begin r = -b;    ov = 1'b0; end
      default: begin r = '0; ov = 1'b0; end
    endcase
  endfunction

  // Called at posedge+1; the start is sampled at the next edge.
  task automatic issue(input logic [1:0] o, input bit ld, input logic [W-1:0] bv);
    sb_t          x;
    logic [W-1:0] r;
    logic         ov;
    int           s;
    s = sel ? 1 : 0;
    if (ld) m_b[s] = bv;
    model(o, m_a[s], m_b[s], r, ov);
    m_a[s] = r;
    x.a   = r;
    x.neg = r[W-1];
    x.zr  = (r == '0);
    x.ov  = ov;
    x.cyc = cyc + 1 + (sel ? N1 : N0);
    sb.push_back(x);
    op         = alu_op_t'(o);
    start      = 1'b1;
    load_b     = ld;
    tb_val     = bv;
    tb_drv     = ld;
    acc_to_bus = !ld;
    @(posedge clk); #1;
    start      = 1'b0;
    load_b     = 1'b0;
    tb_drv     = 1'b0;
    acc_to_bus = 1'b1;
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input bit ld, input logic [W-1:0] bv);
    issue(o, ld, bv);
    wait_done();
  endtask

  always @(negedge clk) begin
    if (prev_done) begin
      tests++;
      if (done_m) begin
        fails++;
        $display("FAIL done_width: done high 2 cycles, expected 1");
      end
    end
    prev_done = done_m;
    if (done_m) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: done=1 at cycle %0d expected 0", cyc);
      end else begin
        e = sb.pop_front();
        chk("result",   bus_m, e.a);
        chk("negative", W'(neg_m), W'(e.neg));
        chk("zero",     W'(zero_m), W'(e.zr));
        chk("overflow", W'(ov_m), W'(e.ov));
        chk("latency",  W'(cyc), W'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] specials[6];

  initial begin
    m_a[0] = '0; m_a[1] = '0; m_b[0] = '0; m_b[1] = '0;
    specials[0] = 32'h0000_0000; specials[1] = 32'h7FFF_FFFF; specials[2] = 32'h8000_0000;
    specials[3] = 32'hFFFF_FFFF; specials[4] = 32'h0000_0001; specials[5] = 32'h8000_0001;

    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy0", W'(if0.busy), '0);
    chk("rst_done0", W'(if0.done), '0);
    chk("rst_flags0", W'({if0.negative, if0.zero, if0.overflow}), '0);
    chk("rst_flags1", W'({if1.busy, if1.done, if1.negative, if1.zero, if1.overflow}), '0);
    chk_z("rst_bus0", bus0);
    chk_z("rst_bus1", bus1);
    @(posedge clk); #1;

    // Serial 1-bit engine: LDN, subtraction, signed overflow.
    sel = 1'b0;
    run(2'd2, 1, 32'h0000_0005);
    run(2'd2, 1, 32'hFFFF_FFF6);
    run(2'd1, 1, 32'h0000_0004);
    run(2'd1, 1, 32'h0000_0006);
    run(2'd2, 1, 32'h8000_0001);
    run(2'd0, 1, 32'h0000_0001);
    run(2'd1, 0, 32'h0000_0000);

    // start/load_b during RUN are ignored; bus stays released while busy.
    issue(2'd0, 0, '0);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = OP_CLR; load_b = 1'b1; tb_drv = 1'b1; acc_to_bus = 1'b0;
    tb_val = $urandom();
    @(posedge clk); #1;
    start = 1'b0; load_b = 1'b0; tb_drv = 1'b0; acc_to_bus = 1'b1;
    @(negedge clk);
    chk("busy_in_run", W'(busy_m), W'(1));
    chk_z("bus_in_run", bus0);
    wait_done();
    run(2'd1, 0, '0);

    // Reset mid-RUN aborts the operation and clears A/B.
    issue(2'd0, 1, 32'h1234_5678);
    repeat (8) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.delete();
    m_a[0] = '0; m_a[1] = '0; m_b[0] = '0; m_b[1] = '0;
    @(negedge clk);
    chk("abort_busy", W'(busy_m), '0);
    chk("abort_flags", W'({done_m, neg_m, zero_m, ov_m}), '0);
    chk("abort_acc", bus0, '0);
    repeat (40) @(posedge clk);
    #1;
    run(2'd0, 0, '0);

    // 4-bit-per-cycle engine.
    sel = 1'b1;
    @(posedge clk); #1;
    run(2'd3, 0, '0);
    run(2'd0, 1, 32'd1000);
    run(2'd0, 1, 32'd2000);
    chk("bpc4_sum_model", m_a[1], 32'h0000_0BB8);

    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      @(posedge clk); #1;
      for (int i = 0; i < 30; i++) begin
        logic [W-1:0] v;
        v = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
        run(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), v);
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssem_serial_alu.md
# ssem_serial_alu

Parametrised bit-serial accumulator ALU for the SSEM datapath. It replaces the fixed 32-bit parallel A/B/ALU trio with a Baby-style serial engine. It is generic in word width and in bits processed per clock, and it adds an explicit start/busy/done handshake, the LDN (load negative) and CLR operations, and status flags. It shares the tristate system bus with the memory and control blocks.

## Interface
- `WIDTH`, 32: word width in bits; must be ≥ 4.
- `BITS_PER_CYCLE`, 1: bits processed per RUN cycle; must divide `WIDTH`. `N = WIDTH/BITS_PER_CYCLE`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `bus` inout WIDTH: shared tristate system bus.
- `load_b` in 1: capture `bus` into operand register B; honoured in IDLE only.
- `acc_to_bus` in 1: drive accumulator A onto `bus` while high and not busy.
- `op` in 2: operation; sampled with `start`. 00 ADD (A←A+B), 01 SUB (A←A−B), 10 LDN (A←−B), 11 CLR (A←0).
- `start` in 1: begin the operation; honoured in IDLE only.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when the result is valid.
- `negative` out 1: A[WIDTH-1] of the last completed result.
- `zero` out 1: last completed result == 0.
- `overflow` out 1: signed overflow of the last completed ADD or SUB; 0 after LDN or CLR.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE→RUN occurs at an edge where `start`=1. That edge latches `op`, loads the chunk counter with N−1 and initialises the carry.
  - Carry-in is 1 for SUB and LDN, where B is inverted (two's complement).
  - Carry-in is 0 for ADD and CLR.
- Each RUN edge processes the low `BITS_PER_CYCLE` bits of A and B:
  - The sum chunk enters the top of A as A shifts right by `BITS_PER_CYCLE`.
  - B rotates right by the same amount, so B is unchanged after N chunks.
  - For LDN and CLR, the A operand is forced to 0. For CLR, the B operand is also forced to 0.
- On the edge that processes chunk N−1:
  - The FSM goes RUN→DONE.
  - `negative`, `zero` and `overflow` are registered. `overflow` is the carry into the MSB XOR the carry out of the MSB, for ADD and SUB only.
- DONE→IDLE occurs unconditionally on the next edge.
- Bus driving:
  - `bus` = A when `acc_to_bus` && !busy; otherwise `bus` is high-Z.
  - This block never drives the bus in RUN.
- Boundary rules:
  - `start` in RUN or DONE is ignored, not queued.
  - `load_b` in RUN or DONE is ignored.
  - `load_b` and `start` in the same IDLE edge: B captures `bus`, and the operation uses that new value.
  - `reset_n` low at any edge, including mid-RUN: next state is IDLE; A, B, carry, counter and all outputs are cleared.
  - `start` during the `reset_n` low edge is ignored.
  - Wrap-around: results are modulo 2^WIDTH.

## Timing
- Reset values: `busy`, `done`, `negative`, `zero` and `overflow` are all 0, A=B=0, and `bus` is Z. Note that `zero` reads 0 after reset even though A=0; it reflects only completed operations.
- Latency: with `start` sampled at edge t, `busy` is high from t to t+N. `done` is high for exactly the cycle after edge t+N, and A and the flags are valid from that cycle.
- Back-to-back: the next `start` is accepted at edge t+N+2 (the first IDLE edge).
  - Throughput is one operation per N+2 cycles.
- `load_b` takes effect at its sampling edge; B is readable by the next operation only.

## Structure
- Put the following in shared package `ssem_pkg`:
  - `alu_op_t` (ADD/SUB/LDN/CLR encodings).
  - `alu_state_t` (IDLE/RUN/DONE).
- Use one sub-module, `ssem_serial_adder_slice`. It is a combinational `BITS_PER_CYCLE`-bit ripple adder with:
  - Inputs: `a_chunk`, `b_chunk` (already inverted and masked by the parent) and `carry_in`.
  - Outputs: `sum_chunk`, `carry_out` and `carry_msb_in` (for overflow).
- The parent module holds A, B, the counter, the carry flop and the FSM.

## Test plan
- Reset: hold `reset_n` low for 3 edges, then release → all outputs 0; `bus`=Z with `acc_to_bus`=1.
- WIDTH=32, BPC=1: `load_b` 0x00000005, then `start` LDN → `done` exactly 32 cycles after the start edge, pulse width 1, A=0xFFFFFFFB, `negative`=1, `zero`=0.
- Subtraction: LDN with B=0xFFFFFFF6 (A=10), then `load_b` 0x4 and SUB → A=0x00000006, `overflow`=0. Then `load_b` 0x6 and SUB → A=0, `zero`=1.
- BPC=4 (N=8): CLR, then `load_b` 1000 and ADD, then `load_b` 2000 and ADD → A=0x00000BB8, each `done` 8 cycles after its start.
- Overflow: A=0x7FFFFFFF, B=0x1, ADD → A=0x80000000, `overflow`=1, `negative`=1. Then A=0x80000000, B=0x1, SUB → 0x7FFFFFFF, `overflow`=1.
- Hazards:
  - `start` and `load_b` pulsed at RUN cycle 5 → ignored, result unchanged.
  - `acc_to_bus`=1 during RUN → `bus`=Z.
  - `reset_n` low at RUN cycle 10 → next cycle `busy`=0, A=0, B=0, and no `done`.
